// File: rtl/seq_fixed_divider.sv
// Multi-cycle signed fixed-point divider: radix-2 restoring iteration producing
// a signed Q(WIDTH).(WIDTH) quotient of a/b with overflow and divide-by-zero flags.
module seq_fixed_divider #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_en,
    input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
    input  logic                 s_axis_dividend_tvalid,
    input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
    input  logic                 s_axis_divisor_tvalid,
    output logic [2*WIDTH-1:0]   m_axis_dout_tdata,
    output logic                 m_axis_dout_tvalid,
    output logic [1:0]           m_axis_dout_tuser,
    output logic                 busy
);

    localparam int QW = 2 * WIDTH;
    localparam int CW = $clog2(QW + 1);

    localparam logic [QW-1:0] POS_MAX = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] NEG_MAX = {1'b1, {(QW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [WIDTH:0]    rem_reg, rem_next;
    logic [QW-1:0]     quo_reg, quo_next;
    logic [QW-1:0]     num_reg, num_next;
    logic [WIDTH-1:0]  div_reg, div_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic              sign_reg, sign_next;
    logic              zero_reg, zero_next;
    logic              aneg_reg, aneg_next;
    logic [QW-1:0]     tdata_reg, tdata_next;
    logic              tvalid_reg, tvalid_next;
    logic [1:0]        tuser_reg, tuser_next;
    logic              busy_reg, busy_next;

    logic [WIDTH-1:0]  a_abs;
    logic [WIDTH-1:0]  b_abs;
    logic [WIDTH:0]    trial;
    logic [WIDTH:0]    div_ext;

    // Magnitudes as unsigned; the most negative operand maps to 2^(WIDTH-1)
    assign a_abs   = s_axis_dividend_tdata[WIDTH-1] ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
    assign b_abs   = s_axis_divisor_tdata[WIDTH-1]  ? -s_axis_divisor_tdata  : s_axis_divisor_tdata;
    assign trial   = {rem_reg[WIDTH-1:0], num_reg[QW-1]};
    assign div_ext = {1'b0, div_reg};

    always_comb begin
        state_next  = state_reg;
        rem_next    = rem_reg;
        quo_next    = quo_reg;
        num_next    = num_reg;
        div_next    = div_reg;
        cnt_next    = cnt_reg;
        sign_next   = sign_reg;
        zero_next   = zero_reg;
        aneg_next   = aneg_reg;
        tdata_next  = tdata_reg;
        tvalid_next = tvalid_reg;
        tuser_next  = tuser_reg;
        busy_next   = busy_reg;

        case (state_reg)
            IDLE: begin
                if (s_axis_dividend_tvalid && s_axis_divisor_tvalid) begin
                    div_next   = b_abs;
                    num_next   = {a_abs, {WIDTH{1'b0}}};
                    sign_next  = s_axis_dividend_tdata[WIDTH-1] ^ s_axis_divisor_tdata[WIDTH-1];
                    zero_next  = (s_axis_divisor_tdata == '0);
                    aneg_next  = s_axis_dividend_tdata[WIDTH-1];
                    rem_next   = '0;
                    quo_next   = '0;
                    cnt_next   = CW'(QW);
                    busy_next  = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                num_next = {num_reg[QW-2:0], 1'b0};
                if (trial >= div_ext) begin
                    rem_next = trial - div_ext;
                    quo_next = {quo_reg[QW-2:0], 1'b1};
                end else begin
                    rem_next = trial;
                    quo_next = {quo_reg[QW-2:0], 1'b0};
                end
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                // Divide-by-zero wins; positive magnitude 2^(QW-1) is the only overflow
                if (zero_reg) begin
                    tdata_next = aneg_reg ? NEG_MAX : POS_MAX;
                    tuser_next = 2'b01;
                end else if (!sign_reg && quo_reg[QW-1]) begin
                    tdata_next = POS_MAX;
                    tuser_next = 2'b10;
                end else begin
                    tdata_next = sign_reg ? -quo_reg : quo_reg;
                    tuser_next = 2'b00;
                end
                tvalid_next = 1'b1;
                state_next  = DONE;
            end
            DONE: begin
                tvalid_next = 1'b0;
                busy_next   = 1'b0;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            rem_reg    <= '0;
            quo_reg    <= '0;
            num_reg    <= '0;
            div_reg    <= '0;
            cnt_reg    <= '0;
            sign_reg   <= 1'b0;
            zero_reg   <= 1'b0;
            aneg_reg   <= 1'b0;
            tdata_reg  <= '0;
            tvalid_reg <= 1'b0;
            tuser_reg  <= '0;
            busy_reg   <= 1'b0;
        end else if (clk_en) begin
            state_reg  <= state_next;
            rem_reg    <= rem_next;
            quo_reg    <= quo_next;
            num_reg    <= num_next;
            div_reg    <= div_next;
            cnt_reg    <= cnt_next;
            sign_reg   <= sign_next;
            zero_reg   <= zero_next;
            aneg_reg   <= aneg_next;
            tdata_reg  <= tdata_next;
            tvalid_reg <= tvalid_next;
            tuser_reg  <= tuser_next;
            busy_reg   <= busy_next;
        end
    end

    assign m_axis_dout_tdata  = tdata_reg;
    assign m_axis_dout_tvalid = tvalid_reg;
    assign m_axis_dout_tuser  = tuser_reg;
    assign busy               = busy_reg;

endmodule

// File: tb/tb_seq_fixed_divider.sv
// Self-checking bench for seq_fixed_divider (WIDTH=16): vector table plus
// stall, streaming, single-valid and mid-division reset sequences.
module tb_seq_fixed_divider;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               clk_en;
    logic [15:0]        a_data;
    logic               a_valid;
    logic [15:0]        b_data;
    logic               b_valid;
    logic [31:0]        dout;
    logic               dout_valid;
    logic [1:0]         dout_user;
    logic               busy;

    int checks = 0;
    int errors = 0;

    seq_fixed_divider #(.WIDTH(16)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .clk_en                 (clk_en),
        .s_axis_dividend_tdata  (a_data),
        .s_axis_dividend_tvalid (a_valid),
        .s_axis_divisor_tdata   (b_data),
        .s_axis_divisor_tvalid  (b_valid),
        .m_axis_dout_tdata      (dout),
        .m_axis_dout_tvalid     (dout_valid),
        .m_axis_dout_tuser      (dout_user),
        .busy                   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic [31:0]        q;
        logic [1:0]         u;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Plain arithmetic reference for nonzero divisors without overflow
    function automatic logic [31:0] ref_div(input int a, input int b);
        longint mag;
        longint aa;
        longint bb;
        aa  = (a < 0) ? -a : a;
        bb  = (b < 0) ? -b : b;
        mag = (aa * 65536) / bb;
        if ((a < 0) != (b < 0)) mag = -mag;
        return mag[31:0];
    endfunction

    function automatic logic stall_off(input int n, input int s_at, input int s_len);
        return (s_len > 0) && (n >= s_at) && (n < s_at + s_len);
    endfunction

    // One request: accept edge is edge 0; exp_lat is the edge after which tvalid is first seen
    task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp_q, input logic [1:0] exp_u,
                           input int s_at, input int s_len,
                           input int exp_lat, input int exp_width, input string name);
        int  n;
        int  w;
        bit  seen;
        @(negedge clk);
        clk_en  = 1'b1;
        a_data  = a;
        b_data  = b;
        a_valid = 1'b1;
        b_valid = 1'b1;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_data  = 16'h1234;
        b_data  = 16'h0001;
        chk({name, "_busy_set"}, {31'd0, busy}, 32'd1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            clk_en = !stall_off(n, s_at, s_len);
            @(posedge clk);
            #1;
            n++;
            if (dout_valid) seen = 1'b1;
        end
        chk({name, "_latency"}, n, exp_lat);
        chk({name, "_tdata"}, dout, exp_q);
        chk({name, "_tuser"}, {30'd0, dout_user}, {30'd0, exp_u});
        $display("div a=%0d b=%0d -> tdata=0x%08h tuser=%b latency=%0d",
                 $signed(a), $signed(b), dout, dout_user, n);
        w = seen ? 1 : 0;
        while (seen && w < 50) begin
            clk_en = !stall_off(n, s_at, s_len);
            @(posedge clk);
            #1;
            n++;
            if (dout_valid) w++;
            else break;
        end
        chk({name, "_pulse_width"}, w, exp_width);
        chk({name, "_busy_clear"}, {31'd0, busy}, 32'd0);
        clk_en = 1'b1;
    endtask

    initial begin
        int n_busy;
        int n_pulse;
        int pulse_idx[2];
        logic [31:0] pulse_dat[2];
        int ai;
        int bi;
        logic [31:0] exp0;
        logic [31:0] exp1;

        vecs[0]  = '{16'sd6,       16'sd3,       32'h0002_0000, 2'b00};
        vecs[1]  = '{16'sd1,       16'sd3,       32'h0000_5555, 2'b00};
        vecs[2]  = '{-16'sd7,      16'sd2,       32'hFFFC_8000, 2'b00};
        vecs[3]  = '{16'sd7,       -16'sd2,      32'hFFFC_8000, 2'b00};
        vecs[4]  = '{-16'sd7,      -16'sd2,      32'h0003_8000, 2'b00};
        vecs[5]  = '{16'sh8000,    -16'sd1,      32'h7FFF_FFFF, 2'b10};
        vecs[6]  = '{16'sh8000,    16'sd1,       32'h8000_0000, 2'b00};
        vecs[7]  = '{16'sd5,       16'sd0,       32'h7FFF_FFFF, 2'b01};
        vecs[8]  = '{-16'sd5,      16'sd0,       32'h8000_0000, 2'b01};
        vecs[9]  = '{16'sd0,       16'sd5,       32'h0000_0000, 2'b00};
        vecs[10] = '{16'sd32767,   16'sd1,       32'h7FFF_0000, 2'b00};
        vecs[11] = '{16'sd1,       16'sh8000,    32'hFFFF_FFFE, 2'b00};
        vecs[12] = '{-16'sd1,      16'sd3,       32'hFFFF_AAAB, 2'b00};
        vecs[13] = '{16'sd32767,   16'sh8000,    32'hFFFF_0002, 2'b00};
        vecs[14] = '{16'sd0,       16'sd0,       32'h7FFF_FFFF, 2'b01};

        rst_n   = 1'b1;
        clk_en  = 1'b1;
        a_data  = '0;
        b_data  = '0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tdata", dout, 32'd0);
        chk("reset_tvalid", {31'd0, dout_valid}, 32'd0);
        chk("reset_tuser", {30'd0, dout_user}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].u, 0, 0, 33, 1,
                    $sformatf("vec%0d", i));
        end

        // Stall mid-CALC delays the pulse; stall while tvalid is high stretches it
        run_div(-16'sd7, 16'sd2, 32'hFFFC_8000, 2'b00, 10, 10, 43, 1, "stall_calc");
        run_div(16'sd6, 16'sd3, 32'h0002_0000, 2'b00, 33, 3, 33, 4, "stall_valid");

        // Dividend valid alone never starts a division
        n_busy = 0;
        n_pulse = 0;
        @(negedge clk);
        a_data  = 16'sd9;
        b_data  = 16'sd3;
        a_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (busy) n_busy++;
            if (dout_valid) n_pulse++;
        end
        a_valid = 1'b0;
        chk("dividend_only_busy", n_busy, 0);
        chk("dividend_only_tvalid", n_pulse, 0);
        $display("dividend-only valid for 12 cycles: busy cycles=%0d pulses=%0d", n_busy, n_pulse);

        // Both valids held high with data changing every cycle
        n_pulse = 0;
        pulse_idx[0] = -1;
        pulse_idx[1] = -1;
        pulse_dat[0] = '0;
        pulse_dat[1] = '0;
        for (int i = 0; i < 76; i++) begin
            @(negedge clk);
            ai = i * 37 - 500;
            bi = (i % 9) + 2;
            a_data  = ai[15:0];
            b_data  = bi[15:0];
            a_valid = 1'b1;
            b_valid = 1'b1;
            @(posedge clk);
            #1;
            if (dout_valid) begin
                if (n_pulse < 2) begin
                    pulse_idx[n_pulse] = i;
                    pulse_dat[n_pulse] = dout;
                end
                n_pulse++;
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        exp0 = ref_div(-500, 2);
        exp1 = ref_div(35 * 37 - 500, (35 % 9) + 2);
        chk("stream_pulse_count", n_pulse, 2);
        chk("stream_first_edge", pulse_idx[0], 33);
        chk("stream_first_data", pulse_dat[0], exp0);
        chk("stream_second_edge", pulse_idx[1], 68);
        chk("stream_second_data", pulse_dat[1], exp1);
        $display("stream: pulses=%0d at edges %0d,%0d data 0x%08h,0x%08h",
                 n_pulse, pulse_idx[0], pulse_idx[1], pulse_dat[0], pulse_dat[1]);
        // Let the in-flight third division drain
        repeat (40) @(posedge clk);
        #1;

        // Reset at edge 20 of a division
        @(negedge clk);
        a_data  = 16'sd6;
        b_data  = 16'sd3;
        a_valid = 1'b1;
        b_valid = 1'b1;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_tdata", dout, 32'd0);
        chk("midreset_tvalid", {31'd0, dout_valid}, 32'd0);
        chk("midreset_tuser", {30'd0, dout_user}, 32'd0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_pulse = 0;
        n_busy = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (dout_valid) n_pulse++;
            if (busy) n_busy++;
        end
        chk("after_reset_no_tvalid", n_pulse, 0);
        chk("after_reset_idle", n_busy, 0);
        $display("reset at edge 20: pulses after release=%0d", n_pulse);
        run_div(-16'sd7, -16'sd2, 32'h0003_8000, 2'b00, 0, 0, 33, 1, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_fixed_divider.md
Name: seq_fixed_divider

Overview:
- Multi-cycle signed fixed-point divider that answers division requests from the matrix-inversion and gain-computation FSMs in the Kalman datapath.
- Accepts a dividend/divisor pair on AXI-stream-style valid inputs and returns a signed Q(WIDTH).(WIDTH) quotient with a one-cycle valid pulse.
- Uses radix-2 restoring iteration: one quotient bit per enabled cycle.

Parameters:
WIDTH, 16, operand width in bits (signed two's complement); the result is 2*WIDTH bits.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clk_en  input  1  clock enable; when low, all state and outputs hold
s_axis_dividend_tdata  input  WIDTH  signed dividend a
s_axis_dividend_tvalid  input  1  dividend valid
s_axis_divisor_tdata  input  WIDTH  signed divisor b
s_axis_divisor_tvalid  input  1  divisor valid
m_axis_dout_tdata  output  2*WIDTH  signed a/b; upper WIDTH bits are the integer part, lower WIDTH bits the fraction
m_axis_dout_tvalid  output  1  result valid, one-cycle pulse
m_axis_dout_tuser  output  2  {overflow, div_by_zero}, qualified by tvalid
busy  output  1  high while a division is in flight

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n).
  - Assertion at any time, including mid-division, forces state IDLE.
  - Clears tdata, tvalid, tuser, busy, remainder and counter to 0.
  - The in-flight result is discarded; no tvalid follows reset release.
- clk_en=0: every register holds, including counter and tvalid; an asserted tvalid stays high until the next enabled edge.
- States: IDLE, CALC, FIX, DONE. All transitions below occur on enabled edges only.
- IDLE:
  - Accept when both tvalid inputs are high. Accept edge = edge 0.
  - On accept, capture |a| and |b| as WIDTH-bit unsigned values (-2^(WIDTH-1) maps to 2^(WIDTH-1)), sign = a[MSB]^b[MSB], zero flag = (b==0), a_neg = a[MSB].
  - Clear the remainder (WIDTH+1 bits) and the 2*WIDTH quotient register; set counter = 2*WIDTH. Go to CALC; busy=1.
  - A single tvalid high alone is ignored.
- CALC, per edge:
  - remainder = {remainder, next numerator bit}. The numerator is |a| MSB-first followed by WIDTH zeros.
  - If remainder ≥ |b|: subtract and shift 1 into the quotient; else shift 0.
  - Decrement counter; at 0 go to FIX (after 2*WIDTH edges).
  - If the zero flag is set, CALC still runs full length; the result is overridden in FIX.
- FIX, one edge:
  - Compute the result: negate Q if sign=1.
  - Overflow when sign=0 and Q ≥ 2^(2*WIDTH-1): saturate to 0x7FFF..F, overflow=1. This occurs only for -2^(WIDTH-1) / -1.
  - Negative results never overflow; -2^(2*WIDTH-1) is representable.
  - div_by_zero overrides: tdata = 0x7FFF..F if a_neg=0, else 0x800..0; overflow=0; div_by_zero=1.
  - Load tdata and tuser; set tvalid=1. Go to DONE.
- DONE, one edge: tvalid←0, busy←0, go to IDLE.
- Latency and data hold:
  - tvalid is high for exactly the one cycle between edge 2*WIDTH+1 and edge 2*WIDTH+2 (33→34 for WIDTH=16).
  - The next accept is possible at edge 2*WIDTH+3 at the earliest.
  - tdata and tuser hold their value until the next FIX; tuser is meaningful only while tvalid is high.
- Inputs arriving while busy are ignored and not queued; input tdata may change after the accept edge without effect.
- Rounding: truncation toward zero on the 2*WIDTH-bit magnitude before sign application.
- No backpressure on the output; the requester must sample on tvalid.

Test Plan:
- WIDTH=16, a=6, b=3 → tdata=0x0002_0000, tuser=00; tvalid pulses for one cycle, exactly 33 enabled edges after the accept edge.
- a=1, b=3 → 0x0000_5555; a=-7, b=2 → 0xFFFC_8000 (-3.5); a=7, b=-2 → 0xFFFC_8000; a=-7, b=-2 → 0x0003_8000.
- a=-32768, b=-1 → 0x7FFF_FFFF, tuser=10. a=-32768, b=1 → 0x8000_0000, tuser=00.
- a=5, b=0 → 0x7FFF_FFFF, tuser=01. a=-5, b=0 → 0x8000_0000, tuser=01.
- Hold both tvalid inputs high continuously with changing data:
  - Only the values present at each accept edge are divided.
  - Back-to-back results are spaced 2*WIDTH+3 edges apart.
  - Dividend tvalid alone → no accept, busy stays 0.
- Stall and reset mid-operation:
  - Pull clk_en low for 10 cycles mid-CALC → tvalid is delayed by exactly 10 cycles with an identical result.
  - Assert rst_n low at edge 20 → all outputs become 0 immediately; no tvalid afterwards; a fresh request after release completes normally.
